i2c_master: RTL and testbench
=============================

Name: i2c_master

Overview:
- Single-transaction I2C master that programs and reads back the equaliser's I2C register map (config byte plus FIR coefficient bytes, addresses 0..29) over SCL/SDA.
- Takes one command from the test/control host through a valid/ready handshake.
- Write: 7-bit device address + W, register address, one data byte.
- Read: register address, repeated START, one data byte.
- Open-drain pads: the block only pulls lines low or releases them. No clock stretching, no multi-master arbitration.

Parameters:
- DIV_QTR, 125, clk cycles per quarter SCL period (50 MHz clk → 100 kHz SCL); legal range 2..65535.
- DEV_ADDR_RST, 7'h6A, reset value of the dev_addr default register used when cmd_dev_sel=0.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high when a command can be accepted (= !busy)
- cmd_rw  in  1  0 = write, 1 = read
- cmd_dev_sel  in  1  0 = use DEV_ADDR_RST, 1 = use cmd_dev_addr
- cmd_dev_addr  in  7  explicit device address
- cmd_reg_addr  in  8  register address byte
- cmd_wdata  in  8  write data byte
- rdata  out  8  byte read; valid when done=1 and cmd was read
- busy  out  1  transaction in progress
- done  out  1  one-cycle pulse at end of every accepted transaction
- ack_error  out  1  NACK seen in the last transaction; valid with done, held until next accept
- scl_oe  out  1  1 = pull SCL low, 0 = release
- sda_oe  out  1  1 = pull SDA low, 0 = release
- sda_in  in  1  synchronised SDA pad value; 2-flop sync is inside this block

Behaviour:
- Reset: scl_oe=0, sda_oe=0, busy=0, done=0, ack_error=0, rdata=0, FSM=IDLE, quarter counter=0. Reset asserted mid-transaction releases both lines immediately, with no STOP generated.
- Accept: on a cycle with cmd_valid & cmd_ready, latch all cmd_* fields. busy=1 from the next cycle. Clear ack_error. cmd_valid while busy is ignored; nothing is queued.
- Timebase: quarter counter counts 0..DIV_QTR-1 while busy and emits a tick at wrap. Every slot (START, bit, Sr, STOP) is exactly 4 quarters, Q0..Q3.
- Data/ACK bit slot:
  - Q0–Q1: SCL low; SDA is set at the start of Q0.
  - Q2–Q3: SCL released.
  - sda_in is sampled at the Q2→Q3 tick.
- START slot: SDA released, SCL released (Q0–Q1); SDA low (Q2); SCL low (Q3).
- Sr slot: same as START. Q0 first releases SDA while SCL is low, then releases SCL.
- STOP slot: SDA low + SCL low (Q0); SCL released (Q1); SDA released (Q2–Q3).
- Bytes are sent MSB first. Address byte = {addr7, rw}.
- FSM states: IDLE, START, ADDR_W, ACK1, REG, ACK2, then branch:
  - write: WDATA, ACK3, STOP, DONE.
  - read: RSTART, ADDR_R, ACK4, RDATA, MNACK, STOP, DONE.
- Byte states use a 3-bit counter 7→0. ACK states release SDA and sample it.
- ACK sample = 1 (NACK) in any ACK state: set ack_error=1, go to STOP directly. rdata is left unchanged.
- RDATA: SDA released; sampled bits shift into rdata MSB first. MNACK: master releases SDA (NACK) for the 9th bit.
- DONE: done=1 for one cycle, busy=0 the same cycle. cmd_ready=1 from the next cycle.
- Frame lengths:
  - Write: 29 slots = 116·DIV_QTR cycles from accept to done (+1 cycle latency).
  - Read: 39 slots = 156·DIV_QTR (+1).
  - NACK on address: 11 slots.
- IDLE: both lines released. No output glitches; scl_oe and sda_oe are registered.

Test Plan:
- Write, DIV_QTR=4, dev default 0x6A, reg 0x05, data 0xA5, slave model ACKs → bus bytes 0xD4, 0x05, 0xA5 with 27 SCL rising edges between START and STOP; done at cycle 465; ack_error=0; register 5 in the model = 0xA5.
- Read, reg 0x03, model returns 0x3C → bytes 0xD4, 0x03, Sr, 0xD5; master NACKs the data byte, then STOP; rdata=0x3C with done at cycle 625.
- cmd_dev_sel=1, cmd_dev_addr=0x50, no device responds → NACK at ACK1, STOP issued, done after 11 slots (177 cycles), ack_error=1.
- Second cmd_valid pulse during busy → ignored: cmd_ready=0, exactly one START on the bus, one done pulse.
- rst_n low at mid-REG byte → scl_oe=sda_oe=0, busy=0 within 0 cycles (async); a new write after reset completes normally.
- Protocol checker across all tests → SDA never changes while SCL is high except START/Sr/STOP; SCL high time ≥ 2·DIV_QTR.

Source files
------------

// File: rtl/i2c_master.sv
// Single-transaction I2C master: one register write or one register read per command.
// Open-drain outputs: scl_oe/sda_oe = 1 pulls the line low, 0 releases it.
module i2c_master #(
    parameter int unsigned DIV_QTR      = 125,
    parameter logic [6:0]  DEV_ADDR_RST = 7'h6A
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic       cmd_dev_sel,
    input  logic [6:0] cmd_dev_addr,
    input  logic [7:0] cmd_reg_addr,
    input  logic [7:0] cmd_wdata,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       ack_error,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       sda_in
);
    typedef enum logic [3:0] {
        IDLE, START, ADDR_W, ACK1, REG, ACK2, WDATA, ACK3,
        RSTART, ADDR_R, ACK4, RDATA, MNACK, STOP, DONE
    } state_t;

    state_t      state;
    logic [15:0] qcnt;
    logic [1:0]  qtr;
    logic [2:0]  bcnt;
    logic        rw_q;
    logic [6:0]  dev_q;
    logic [7:0]  reg_q;
    logic [7:0]  wdata_q;
    logic        sda_meta;
    logic        sda_s;
    logic        samp;
    logic        tick;
    logic        tx_bit;
    logic [7:0]  tx_byte;
    logic        scl_nxt;
    logic        sda_nxt;

    assign tick      = (qcnt == 16'(DIV_QTR - 1));
    assign cmd_ready = ~busy;

    always_comb begin
        tx_byte = 8'h00;
        case (state)
            ADDR_W:  tx_byte = {dev_q, 1'b0};
            ADDR_R:  tx_byte = {dev_q, 1'b1};
            REG:     tx_byte = reg_q;
            WDATA:   tx_byte = wdata_q;
            default: tx_byte = 8'h00;
        endcase
    end
    assign tx_bit = tx_byte[bcnt];

    // Line levels for the current slot/quarter; registered below so the pads never glitch.
    always_comb begin
        scl_nxt = 1'b0;
        sda_nxt = 1'b0;
        case (state)
            START, RSTART: begin
                // Sr first drops SCL with SDA released so a slave ACK can let go of SDA
                scl_nxt = (qtr == 2'd3) || (state == RSTART && qtr == 2'd0);
                sda_nxt = qtr[1];
            end
            ADDR_W, ADDR_R, REG, WDATA: begin
                scl_nxt = ~qtr[1];
                sda_nxt = ~tx_bit;
            end
            ACK1, ACK2, ACK3, ACK4, RDATA, MNACK: scl_nxt = ~qtr[1];
            STOP: begin
                scl_nxt = (qtr == 2'd0);
                sda_nxt = ~qtr[1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            qcnt      <= 16'd0;
            qtr       <= 2'd0;
            bcnt      <= 3'd7;
            rw_q      <= 1'b0;
            dev_q     <= DEV_ADDR_RST;
            reg_q     <= 8'h00;
            wdata_q   <= 8'h00;
            sda_meta  <= 1'b1;
            sda_s     <= 1'b1;
            samp      <= 1'b1;
            rdata     <= 8'h00;
            busy      <= 1'b0;
            done      <= 1'b0;
            ack_error <= 1'b0;
            scl_oe    <= 1'b0;
            sda_oe    <= 1'b0;
        end else begin
            sda_meta <= sda_in;
            sda_s    <= sda_meta;
            scl_oe   <= scl_nxt;
            sda_oe   <= sda_nxt;
            done     <= 1'b0;
            case (state)
                IDLE: if (cmd_valid) begin
                    rw_q      <= cmd_rw;
                    dev_q     <= cmd_dev_sel ? cmd_dev_addr : DEV_ADDR_RST;
                    reg_q     <= cmd_reg_addr;
                    wdata_q   <= cmd_wdata;
                    ack_error <= 1'b0;
                    busy      <= 1'b1;
                    qcnt      <= 16'd0;
                    qtr       <= 2'd0;
                    bcnt      <= 3'd7;
                    state     <= START;
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: if (!tick) begin
                    qcnt <= qcnt + 16'd1;
                end else begin
                    qcnt <= 16'd0;
                    qtr  <= qtr + 2'd1;
                    if (qtr == 2'd2) begin
                        samp <= sda_s;
                        if (state == RDATA) rdata <= {rdata[6:0], sda_s};
                    end
                    if (qtr == 2'd3) begin
                        // bcnt wraps 0 -> 7, so it is ready for the next byte on exit
                        case (state)
                            START:  state <= ADDR_W;
                            RSTART: state <= ADDR_R;
                            ADDR_W: begin bcnt <= bcnt - 3'd1; if (bcnt == 3'd0) state <= ACK1; end
                            REG:    begin bcnt <= bcnt - 3'd1; if (bcnt == 3'd0) state <= ACK2; end
                            WDATA:  begin bcnt <= bcnt - 3'd1; if (bcnt == 3'd0) state <= ACK3; end
                            ADDR_R: begin bcnt <= bcnt - 3'd1; if (bcnt == 3'd0) state <= ACK4; end
                            RDATA:  begin bcnt <= bcnt - 3'd1; if (bcnt == 3'd0) state <= MNACK; end
                            ACK1: begin
                                ack_error <= samp;
                                state     <= samp ? STOP : REG;
                            end
                            ACK2: begin
                                ack_error <= samp;
                                state     <= samp ? STOP : (rw_q ? RSTART : WDATA);
                            end
                            ACK3: begin
                                ack_error <= samp;
                                state     <= STOP;
                            end
                            ACK4: begin
                                ack_error <= samp;
                                state     <= samp ? STOP : RDATA;
                            end
                            MNACK:   state <= STOP;
                            STOP:    state <= DONE;
                            default: state <= IDLE;
                        endcase
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_master.sv
// Bench for i2c_master: open-drain bus with a behavioural slave/monitor and a register-map model.
module tb_i2c_master;
    localparam int         DIV = 4;
    localparam logic [6:0] SLV = 7'h6A;
    localparam logic [31:0] M_START = 32'h100;
    localparam logic [31:0] M_STOP  = 32'h200;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_rw = 1'b0;
    logic       cmd_dev_sel = 1'b0;
    logic [6:0] cmd_dev_addr = 7'h00;
    logic [7:0] cmd_reg_addr = 8'h00;
    logic [7:0] cmd_wdata = 8'h00;
    logic [7:0] rdata;
    logic       busy, done, ack_error, scl_oe, sda_oe;
    logic       sda_in;
    logic       scl, sda;
    logic       slv_pull = 1'b0;

    always #5 clk = ~clk;

    assign scl    = ~scl_oe;
    assign sda    = ~(sda_oe | slv_pull);
    assign sda_in = sda;

    i2c_master #(.DIV_QTR(DIV), .DEV_ADDR_RST(SLV)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_rw(cmd_rw), .cmd_dev_sel(cmd_dev_sel), .cmd_dev_addr(cmd_dev_addr),
        .cmd_reg_addr(cmd_reg_addr), .cmd_wdata(cmd_wdata), .rdata(rdata),
        .busy(busy), .done(done), .ack_error(ack_error),
        .scl_oe(scl_oe), .sda_oe(sda_oe), .sda_in(sda_in)
    );

    // ---------------- bus monitor + slave device (only writer of its state) ----------------
    logic [31:0] bus_q[$];
    logic [31:0] ack_q[$];
    logic [7:0]  slv_mem [256];
    int          clr_id = 0, clr_seen = 0;
    int          pulses = 0, min_hi = 1000, hi_len = 0, done_cnt = 0;
    bit          hi_seen = 0;
    logic        p_scl = 1'b1, p_sda = 1'b1;
    int          bitcnt = 0, nbyte = 0;
    bit          active = 0, rd_mode = 0, byte_rd = 0;
    logic [7:0]  sh = 8'h00, tx = 8'h00, reg_ptr = 8'h00;

    always @(negedge clk) begin
        logic c_scl, c_sda;
        c_scl = scl;
        c_sda = sda;
        if (clr_id != clr_seen) begin
            clr_seen = clr_id;
            bus_q.delete();
            ack_q.delete();
            pulses = 0; min_hi = 1000; done_cnt = 0; hi_seen = 0;
        end
        if (done === 1'b1) done_cnt++;
        if (p_scl && c_scl && p_sda && !c_sda) begin
            bus_q.push_back(M_START);
            bitcnt = 0; nbyte = 0; active = 0; rd_mode = 0; byte_rd = 0; slv_pull = 1'b0;
        end else if (p_scl && c_scl && !p_sda && c_sda) begin
            bus_q.push_back(M_STOP);
            active = 0; rd_mode = 0; slv_pull = 1'b0;
        end else if (c_scl && !p_scl) begin
            hi_len = 0;
            hi_seen = 1;
            if (bitcnt < 8) begin
                sh = {sh[6:0], c_sda};
                bitcnt++;
                if (bitcnt == 8) begin
                    bus_q.push_back(32'(sh));
                    byte_rd = rd_mode;
                    if (!rd_mode) begin
                        if (nbyte == 0) begin
                            active  = (sh[7:1] == SLV);
                            rd_mode = active && sh[0];
                            if (rd_mode) tx = slv_mem[reg_ptr];
                        end else if (active && nbyte == 1) reg_ptr = sh;
                        else if (active) slv_mem[reg_ptr] = sh;
                    end
                    nbyte++;
                end
            end else begin
                ack_q.push_back(32'(c_sda));
                bitcnt = 0;
                if (byte_rd && c_sda) begin rd_mode = 0; active = 0; end
            end
        end else if (!c_scl && p_scl) begin
            if (hi_seen) begin
                pulses++;
                if (hi_len < min_hi) min_hi = hi_len;
            end
            hi_seen = 0;
            if (bitcnt == 8)  slv_pull = active && !byte_rd;
            else if (rd_mode) slv_pull = ~tx[3'(7 - bitcnt)];
            else              slv_pull = 1'b0;
        end
        if (c_scl) hi_len++;
        p_scl = c_scl;
        p_sda = c_sda;
    end

    // ---------------- reference model + checking ----------------
    logic [7:0] ref_mem [256];
    logic [7:0] exp_rdata = 8'h00;
    int         n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_cmd(input logic rw, input logic sel, input logic [6:0] dev,
                          input logic [7:0] ra, input logic [7:0] wd, input int poke_at);
        logic [6:0]  a;
        logic        acked;
        int          nbytes, slots, npulse, cyc;
        logic [31:0] q_exp[$];
        logic [31:0] a_exp[$];
        a      = sel ? dev : SLV;
        acked  = (a == SLV);
        // bytes on the bus: each is 9 SCL pulses; a read adds one Sr slot
        nbytes = !acked ? 1 : (rw ? 4 : 3);
        slots  = 2 + 9 * nbytes + ((rw && acked) ? 1 : 0);
        npulse = 9 * nbytes + ((rw && acked) ? 1 : 0);
        q_exp.push_back(M_START);
        q_exp.push_back(32'({a, 1'b0}));
        if (!acked) a_exp.push_back(32'd1);
        else if (!rw) begin
            q_exp.push_back(32'(ra)); q_exp.push_back(32'(wd));
            a_exp = '{32'd0, 32'd0, 32'd0};
        end else begin
            q_exp.push_back(32'(ra)); q_exp.push_back(M_START);
            q_exp.push_back(32'({a, 1'b1})); q_exp.push_back(32'(ref_mem[ra]));
            a_exp = '{32'd0, 32'd0, 32'd0, 32'd1};
        end
        q_exp.push_back(M_STOP);

        clr_id++;
        @(negedge clk);
        cmd_rw = rw; cmd_dev_sel = sel; cmd_dev_addr = dev;
        cmd_reg_addr = ra; cmd_wdata = wd; cmd_valid = 1'b1;
        chk("ready_idle", 32'(cmd_ready), 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("busy_accept", 32'(busy), 1);
        cyc = 0;
        while (done !== 1'b1 && cyc < 4 * DIV * slots + 50) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == poke_at) begin
                chk("ready_busy", 32'(cmd_ready), 0);
                cmd_valid = 1'b1; cmd_rw = ~rw; cmd_reg_addr = ra + 8'd1;
            end else cmd_valid = 1'b0;
        end
        cmd_valid = 1'b0;
        chk("done_cycle", 32'(cyc), 32'(4 * DIV * slots + 1));
        chk("ack_error", 32'(ack_error), 32'(!acked));
        if (rw && acked) exp_rdata = ref_mem[ra];
        if (!rw && acked) ref_mem[ra] = wd;
        chk("rdata", 32'(rdata), 32'(exp_rdata));
        repeat (4) @(posedge clk);
        #1;
        chk("busy_end", 32'(busy), 0);
        chk("ready_end", 32'(cmd_ready), 1);
        chk("done_pulses", 32'(done_cnt), 1);
        chk("ack_error_held", 32'(ack_error), 32'(!acked));
        chk("lines_idle", 32'({scl_oe, sda_oe}), 0);
        if (!rw && acked) chk("slave_reg", 32'(slv_mem[ra]), 32'(ref_mem[ra]));
        chk("bus_len", 32'(bus_q.size()), 32'(q_exp.size()));
        for (int i = 0; i < q_exp.size() && i < bus_q.size(); i++)
            chk($sformatf("bus_item%0d", i), bus_q[i], q_exp[i]);
        chk("ack_len", 32'(ack_q.size()), 32'(a_exp.size()));
        for (int i = 0; i < a_exp.size() && i < ack_q.size(); i++)
            chk($sformatf("ack_bit%0d", i), ack_q[i], a_exp[i]);
        chk("scl_pulses", 32'(pulses), 32'(npulse));
        chk("scl_high_min", 32'(min_hi >= 2 * DIV), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_lines", 32'({scl_oe, sda_oe}), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_ack_error", 32'(ack_error), 0);
        chk("rst_rdata", 32'(rdata), 0);
        chk("rst_ready", 32'(cmd_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        do_cmd(1'b0, 1'b0, 7'h00, 8'h05, 8'hA5, 0);
        do_cmd(1'b0, 1'b0, 7'h00, 8'h03, 8'h3C, 0);
        do_cmd(1'b1, 1'b0, 7'h00, 8'h03, 8'h00, 0);
        do_cmd(1'b0, 1'b1, 7'h50, 8'h07, 8'h99, 0);
        do_cmd(1'b1, 1'b1, 7'h50, 8'h05, 8'h00, 0);
        do_cmd(1'b0, 1'b0, 7'h00, 8'h09, 8'h5E, 100);

        // abort a write in the middle of the register byte
        clr_id++;
        @(negedge clk);
        cmd_rw = 1'b0; cmd_dev_sel = 1'b0; cmd_reg_addr = 8'h07; cmd_wdata = 8'hEE; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (13 * 4 * DIV) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_lines", 32'({scl_oe, sda_oe}), 0);
        chk("async_rst_busy", 32'(busy), 0);
        chk("async_rst_ready", 32'(cmd_ready), 1);
        exp_rdata = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        do_cmd(1'b0, 1'b0, 7'h00, 8'h07, 8'h42, 0);
        do_cmd(1'b1, 1'b0, 7'h00, 8'h07, 8'h00, 0);

        for (int r = 0; r < 30; r++) do_cmd(1'b0, 1'b0, 7'h00, 8'(r), 8'($urandom), 0);
        for (int k = 0; k < 12; k++) begin
            logic       rw, sel;
            logic [6:0] dev;
            rw  = 1'($urandom_range(0, 1));
            sel = ($urandom_range(0, 3) == 0);
            dev = ($urandom_range(0, 1) == 1) ? SLV : 7'($urandom);
            do_cmd(rw, sel, sel ? dev : 7'h00, 8'($urandom_range(0, 29)), 8'($urandom), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
